// File: rtl/alu_op_sequencer_if.sv
// Request/response bundle between the execute control unit and the ALU op sequencer.
// The control unit is the master (issues operations, consumes results);
// the sequencer is the slave.
interface alu_op_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic       flag_c_in;
    logic       flag_v_in;
    logic       flag_d_in;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_n;
    logic       rsp_z;
    logic       rsp_c;
    logic       rsp_v;
    logic       rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, flag_c_in, flag_v_in, flag_d_in, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_n, rsp_z, rsp_c, rsp_v, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, flag_c_in, flag_v_in, flag_d_in, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_n, rsp_z, rsp_c, rsp_v, rsp_err
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Runs one 6502 instruction-level ALU operation at a time through the shared
// combinational ALU: decodes the op into one-hot ALU controls and conditioned
// operands, lets the ALU settle for one cycle, then captures and post-processes
// the result into a byte plus N/Z/C/V held until the consumer accepts it.
module alu_op_sequencer #(
    parameter bit DECIMAL_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_op_sequencer_if.slave bus,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic              alu_sums,
    output logic              alu_ands,
    output logic              alu_ors,
    output logic              alu_eors,
    output logic              alu_srs,
    output logic              alu_bcds,
    output logic              alu_cin,
    input  logic [7:0]        alu_result,
    input  logic              alu_of,
    input  logic              alu_cout
);

    localparam logic [3:0] OP_ADC = 4'd0;
    localparam logic [3:0] OP_SBC = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_ORA = 4'd3;
    localparam logic [3:0] OP_EOR = 4'd4;
    localparam logic [3:0] OP_LSR = 4'd5;
    localparam logic [3:0] OP_ROR = 4'd6;
    localparam logic [3:0] OP_ASL = 4'd7;
    localparam logic [3:0] OP_ROL = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;
    localparam logic [3:0] OP_INC = 4'd10;
    localparam logic [3:0] OP_DEC = 4'd11;
    localparam logic [3:0] OP_BIT = 4'd12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic       ready_q;
    logic       accept;

    // Operation latched at accept; the post-processing works from these copies.
    logic [3:0] op_q;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic       c_q;
    logic       v_q;

    // Decoded ALU drive, ordered {sums, ands, ors, eors, srs, bcds, cin}.
    logic [6:0] ctrl_d;
    logic [6:0] ctrl_q;
    logic [7:0] dec_a;
    logic [7:0] dec_b;
    logic       dec_d;

    // Post-processed response, loaded at the end of the ISSUE cycle.
    logic [7:0] res_d;
    logic       n_d;
    logic       z_d;
    logic       c_d;
    logic       v_d;
    logic       err_d;
    logic       nz_fixed;

    logic       rsp_valid_q;
    logic [7:0] rsp_result_q;
    logic       rsp_n_q;
    logic       rsp_z_q;
    logic       rsp_c_q;
    logic       rsp_v_q;
    logic       rsp_err_q;

    assign accept = bus.req_valid & ready_q;

    // Next-state logic: one fixed pass IDLE -> ISSUE -> CAPTURE -> RESP, leaving RESP on handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; ready is registered so it stays low throughout reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= (state_d == IDLE);
            rsp_valid_q <= (state_d == RESP);
        end
    end

    // Decode the incoming request into ALU controls and conditioned operands.
    always_comb begin
        dec_d  = bus.flag_d_in & DECIMAL_EN;
        dec_a  = bus.req_a;
        dec_b  = bus.req_b;
        ctrl_d = 7'b0000000;
        case (bus.req_op)
            OP_ADC: ctrl_d = {1'b1, 4'b0000, dec_d, bus.flag_c_in};
            OP_SBC: begin
                dec_b  = dec_d ? (8'h99 - bus.req_b) : ~bus.req_b;
                ctrl_d = {1'b1, 4'b0000, dec_d, bus.flag_c_in};
            end
            OP_AND, OP_BIT: ctrl_d = 7'b0100000;
            OP_ORA: ctrl_d = 7'b0010000;
            OP_EOR: ctrl_d = 7'b0001000;
            OP_LSR, OP_ROR: ctrl_d = 7'b0000100;
            OP_ASL: begin
                dec_b  = bus.req_a;
                ctrl_d = 7'b1000000;
            end
            OP_ROL: begin
                dec_b  = bus.req_a;
                ctrl_d = {1'b1, 5'b00000, bus.flag_c_in};
            end
            OP_CMP: begin
                dec_b  = ~bus.req_b;
                ctrl_d = 7'b1000001;
            end
            OP_INC: begin
                dec_b  = 8'h01;
                ctrl_d = 7'b1000000;
            end
            OP_DEC: begin
                dec_b  = 8'hFF;
                ctrl_d = 7'b1000000;
            end
            default: ctrl_d = 7'b0000000;
        endcase
    end

    // ALU drive registers: controls live only for the ISSUE cycle, operands hold their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= 7'b0000000;
            alu_a  <= 8'h00;
            alu_b  <= 8'h00;
            op_q   <= 4'h0;
            a_q    <= 8'h00;
            b_q    <= 8'h00;
            c_q    <= 1'b0;
            v_q    <= 1'b0;
        end else if (accept) begin
            ctrl_q <= ctrl_d;
            alu_a  <= dec_a;
            alu_b  <= dec_b;
            op_q   <= bus.req_op;
            a_q    <= bus.req_a;
            b_q    <= bus.req_b;
            c_q    <= bus.flag_c_in;
            v_q    <= bus.flag_v_in;
        end else begin
            ctrl_q <= 7'b0000000;
        end
    end

    assign {alu_sums, alu_ands, alu_ors, alu_eors, alu_srs, alu_bcds, alu_cin} = ctrl_q;

    // Turn the raw ALU output into the architectural result and flags; shift carries come from A.
    always_comb begin
        res_d    = alu_result;
        n_d      = 1'b0;
        z_d      = 1'b0;
        c_d      = c_q;
        v_d      = v_q;
        err_d    = 1'b0;
        nz_fixed = 1'b0;
        case (op_q)
            OP_ADC, OP_SBC: begin
                c_d = alu_cout;
                v_d = alu_of;
            end
            OP_AND, OP_ORA, OP_EOR, OP_INC, OP_DEC: res_d = alu_result;
            OP_LSR: begin
                res_d = {1'b0, alu_result[6:0]};
                c_d   = a_q[0];
            end
            OP_ROR: begin
                res_d = {c_q, alu_result[6:0]};
                c_d   = a_q[0];
            end
            OP_ASL, OP_ROL: c_d = a_q[7];
            OP_CMP: begin
                res_d    = a_q;
                c_d      = alu_cout;
                n_d      = alu_result[7];
                z_d      = (alu_result == 8'h00);
                nz_fixed = 1'b1;
            end
            OP_BIT: begin
                res_d    = a_q;
                n_d      = b_q[7];
                v_d      = b_q[6];
                z_d      = ((a_q & b_q) == 8'h00);
                nz_fixed = 1'b1;
            end
            default: begin
                res_d = a_q;
                err_d = 1'b1;
            end
        endcase
        if (!nz_fixed) begin
            n_d = res_d[7];
            z_d = (res_d == 8'h00);
        end
    end

    // Capture the response once the ALU has had the whole ISSUE cycle to settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result_q <= 8'h00;
            rsp_n_q      <= 1'b0;
            rsp_z_q      <= 1'b0;
            rsp_c_q      <= 1'b0;
            rsp_v_q      <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else if (state_q == ISSUE) begin
            rsp_result_q <= res_d;
            rsp_n_q      <= n_d;
            rsp_z_q      <= z_d;
            rsp_c_q      <= c_d;
            rsp_v_q      <= v_d;
            rsp_err_q    <= err_d;
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_n      = rsp_n_q;
    assign bus.rsp_z      = rsp_z_q;
    assign bus.rsp_c      = rsp_c_q;
    assign bus.rsp_v      = rsp_v_q;
    assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 6502 ALU attached to
// its ALU port; expected results are hand-computed constants.
module tb_alu_op_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_sums;
    logic       alu_ands;
    logic       alu_ors;
    logic       alu_eors;
    logic       alu_srs;
    logic       alu_bcds;
    logic       alu_cin;
    logic [7:0] alu_result;
    logic       alu_of;
    logic       alu_cout;

    int         checks;
    int         errors;
    logic [7:0] issue_alu_b;
    logic [6:0] issue_ctrl;

    logic [8:0] bin_sum;
    logic [4:0] bcd_lo;
    logic [4:0] bcd_hi;
    logic       bcd_lo_c;

    alu_op_sequencer_if bus ();

    alu_op_sequencer #(.DECIMAL_EN(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sums   (alu_sums),
        .alu_ands   (alu_ands),
        .alu_ors    (alu_ors),
        .alu_eors   (alu_eors),
        .alu_srs    (alu_srs),
        .alu_bcds   (alu_bcds),
        .alu_cin    (alu_cin),
        .alu_result (alu_result),
        .alu_of     (alu_of),
        .alu_cout   (alu_cout)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural combinational ALU: binary/decimal add, logic ops and shift right.
    always_comb begin
        alu_result = 8'h00;
        alu_of     = 1'b0;
        alu_cout   = 1'b0;
        bin_sum    = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
        bcd_lo     = 5'd0;
        bcd_hi     = 5'd0;
        bcd_lo_c   = 1'b0;
        if (alu_sums) begin
            alu_of = (alu_a[7] == alu_b[7]) && (bin_sum[7] != alu_a[7]);
            if (alu_bcds) begin
                bcd_lo   = {1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]} + {4'h0, alu_cin};
                bcd_lo_c = (bcd_lo > 5'd9);
                if (bcd_lo_c) bcd_lo = bcd_lo + 5'd6;
                bcd_hi   = {1'b0, alu_a[7:4]} + {1'b0, alu_b[7:4]} + {4'h0, bcd_lo_c};
                if (bcd_hi > 5'd9) begin
                    bcd_hi   = bcd_hi + 5'd6;
                    alu_cout = 1'b1;
                end
                alu_result = {bcd_hi[3:0], bcd_lo[3:0]};
            end else begin
                alu_result = bin_sum[7:0];
                alu_cout   = bin_sum[8];
            end
        end else if (alu_ands) begin
            alu_result = alu_a & alu_b;
        end else if (alu_ors) begin
            alu_result = alu_a | alu_b;
        end else if (alu_eors) begin
            alu_result = alu_a ^ alu_b;
        end else if (alu_srs) begin
            alu_result = {alu_cin, alu_a[7:1]};
            alu_cout   = alu_a[0];
        end
    end

    // Counts one comparison and reports it when the observed value differs.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Compares the whole response bundle against hand-computed values.
    task automatic checkRsp(input string tag, input logic [7:0] res, input logic n, input logic z,
                            input logic c, input logic v, input logic err);
        checkOutput(tag,
                    {51'd0, bus.rsp_err, bus.rsp_n, bus.rsp_z, bus.rsp_c, bus.rsp_v, bus.rsp_result},
                    {51'd0, err, n, z, c, v, res});
    endtask

    // Issues one request, records the ALU drive seen during ISSUE and waits for the response.
    task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic c, input logic v, input logic d);
        int n;
        int lat;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("ready_before_req", {63'd0, bus.req_ready}, 64'd1);
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.flag_c_in = c;
        bus.flag_v_in = v;
        bus.flag_d_in = d;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        issue_alu_b = alu_b;
        issue_ctrl  = {alu_sums, alu_ands, alu_ors, alu_eors, alu_srs, alu_bcds, alu_cin};
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("latency", 64'(lat), 64'd2);
    endtask

    // Completes the response handshake and confirms the sequencer is back to idle.
    task automatic endOp();
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        checkOutput("rsp_drop", {62'd0, bus.rsp_valid, bus.req_ready}, 64'd1);
    endtask

    // Directed test sequence.
    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 4'h0;
        bus.req_a     = 8'h00;
        bus.req_b     = 8'h00;
        bus.flag_c_in = 1'b0;
        bus.flag_v_in = 1'b0;
        bus.flag_d_in = 1'b0;
        bus.rsp_ready = 1'b0;

        #1;
        checkOutput("reset_outputs",
                    {26'd0, bus.req_ready, bus.rsp_valid, bus.rsp_result, bus.rsp_n, bus.rsp_z,
                     bus.rsp_c, bus.rsp_v, bus.rsp_err, alu_a, alu_b, alu_sums, alu_ands, alu_ors,
                     alu_eors, alu_srs, alu_bcds, alu_cin}, 64'd0);
        #21;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("ready_after_reset", {62'd0, bus.req_ready, bus.rsp_valid}, 64'd2);

        applyStimulus(4'd0, 8'h50, 8'h50, 1'b0, 1'b0, 1'b0);
        checkRsp("adc_bin", 8'hA0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        endOp();

        applyStimulus(4'd0, 8'h19, 8'h28, 1'b0, 1'b0, 1'b1);
        checkOutput("adc_bcd_ctrl", {57'd0, issue_ctrl}, 64'b1000010);
        checkRsp("adc_bcd", 8'h47, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        endOp();

        applyStimulus(4'd1, 8'h10, 8'h01, 1'b1, 1'b0, 1'b1);
        checkOutput("sbc_bcd_alu_b", {56'd0, issue_alu_b}, 64'h98);
        checkRsp("sbc_bcd", 8'h09, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        endOp();

        applyStimulus(4'd1, 8'h05, 8'h06, 1'b1, 1'b0, 1'b0);
        checkOutput("sbc_bin_alu_b", {56'd0, issue_alu_b}, 64'hF9);
        checkRsp("sbc_bin", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        endOp();

        applyStimulus(4'd9, 8'h10, 8'h10, 1'b0, 1'b1, 1'b0);
        checkOutput("cmp_ctrl", {57'd0, issue_ctrl}, 64'b1000001);
        checkRsp("cmp_eq", 8'h10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        endOp();

        applyStimulus(4'd6, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("ror_ctrl", {57'd0, issue_ctrl}, 64'b0000100);
        checkRsp("ror", 8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        endOp();

        applyStimulus(4'd7, 8'h80, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("asl_alu_b", {56'd0, issue_alu_b}, 64'h80);
        checkRsp("asl", 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        endOp();

        applyStimulus(4'd12, 8'h0F, 8'hC0, 1'b0, 1'b0, 1'b0);
        checkRsp("bit", 8'h0F, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        endOp();

        applyStimulus(4'd2, 8'hF0, 8'h3C, 1'b1, 1'b0, 1'b0);
        checkRsp("and", 8'h30, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        endOp();

        applyStimulus(4'd3, 8'h0F, 8'h30, 1'b0, 1'b1, 1'b0);
        checkRsp("ora", 8'h3F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        endOp();

        applyStimulus(4'd4, 8'hFF, 8'h0F, 1'b0, 1'b0, 1'b0);
        checkRsp("eor", 8'hF0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        endOp();

        applyStimulus(4'd5, 8'h81, 8'h00, 1'b1, 1'b0, 1'b0);
        checkRsp("lsr", 8'h40, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        endOp();

        applyStimulus(4'd8, 8'h40, 8'h00, 1'b1, 1'b0, 1'b0);
        checkRsp("rol", 8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        endOp();

        applyStimulus(4'd10, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0);
        checkOutput("inc_alu_b", {56'd0, issue_alu_b}, 64'h01);
        checkRsp("inc_wrap", 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        endOp();

        applyStimulus(4'd11, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        checkRsp("dec_wrap", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        endOp();

        // Stalled consumer: response must hold and a new request must be ignored.
        applyStimulus(4'd0, 8'h50, 8'h50, 1'b0, 1'b0, 1'b0);
        bus.req_op    = 4'd2;
        bus.req_a     = 8'hF0;
        bus.req_b     = 8'h3C;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkOutput("stall_valid_ready", {62'd0, bus.rsp_valid, bus.req_ready}, 64'd2);
            checkRsp("stall_hold", 8'hA0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        bus.req_valid = 1'b0;
        endOp();
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("stall_no_ghost", {62'd0, bus.rsp_valid, bus.req_ready}, 64'd1);

        // Asynchronous reset in the middle of ISSUE.
        bus.req_op    = 4'd0;
        bus.req_a     = 8'h50;
        bus.req_b     = 8'h50;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        checkOutput("issue_sums", {63'd0, alu_sums}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_outputs",
                    {26'd0, bus.req_ready, bus.rsp_valid, bus.rsp_result, bus.rsp_n, bus.rsp_z,
                     bus.rsp_c, bus.rsp_v, bus.rsp_err, alu_a, alu_b, alu_sums, alu_ands, alu_ors,
                     alu_eors, alu_srs, alu_bcds, alu_cin}, 64'd0);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("ready_after_midreset", {62'd0, bus.req_ready, bus.rsp_valid}, 64'd2);
        @(posedge clk); #1;
        checkOutput("no_stale_rsp", {62'd0, bus.req_ready, bus.rsp_valid}, 64'd2);

        applyStimulus(4'd14, 8'h5A, 8'h00, 1'b1, 1'b1, 1'b0);
        checkOutput("illegal_ctrl", {57'd0, issue_ctrl}, 64'd0);
        checkRsp("illegal", 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        endOp();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
